uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receive stage downstream of the UART transmitter. Samples the async rx line, detects
//  start bit, recovers 8 data bits (LSB first) at bit centres, checks stop bit, presents byte.
//  8N1 framing, same parameters as the transmitter so both ends share one baud_tick.
// PARAMETERS
//  clk_freq   50_000_000  system clock frequency, Hz
//  baud_rate  9600        line rate, bit/s
//  baud_tick  (local)     clk_freq/baud_rate clocks per bit (5208 at defaults); half_tick = baud_tick/2
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-low (0 = reset)
//  rx         in   1  serial line, idle high, asynchronous to clk
//  rx_data    out  8  last correctly framed byte; held until next good frame
//  rx_done    out  1  1-cycle pulse: rx_data updated with new byte
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0; rx_data not updated
//  busy       out  1  high in START/DATA/STOP
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rx_data=8'h00, rx_done=0, frame_err=0, busy=0,
//   baud_cnt=0, bit_cnt=0, sync FFs=1, armed=0. Deassertion mid-frame: frame is discarded.
//  Input: 2-FF synchroniser on rx -> rx_s (2 clk delay). All decisions use rx_s only.
//  baud_cnt 13 bits (must hold baud_tick-1); bit_cnt 4 bits.
//  IDLE: armed<=1 when rx_s==1. If armed && rx_s==0 -> START, baud_cnt<=0, busy<=1.
//   Line low from reset/break never starts a frame until a high is seen.
//  START: count to half_tick-1, then sample rx_s:
//   0 -> DATA, baud_cnt<=0, bit_cnt<=0 ; 1 -> glitch, IDLE (no pulse, armed stays 1).
//  DATA: each time baud_cnt==baud_tick-1 sample rx_s into shift[7] (shift right),
//   bit_cnt++, baud_cnt<=0; after 8th sample -> STOP. Else baud_cnt++.
//  STOP: at baud_cnt==baud_tick-1 sample rx_s:
//   1 -> rx_data<=shift, rx_done<=1 next cycle, IDLE.
//   0 -> frame_err<=1 next cycle, armed<=0 (wait for line high), IDLE.
//  rx_done and frame_err are registered, never both high, exactly one clock wide.
//  Latency: rx_done rises 1 clk after stop-bit centre sample (~9.5 bit times + 3 clk from
//   start-bit falling edge on rx).
//  Back-to-back frames: new start bit accepted in IDLE on the cycle after STOP returns;
//   half-bit slack from centre sampling covers it; no overrun storage, consumer must
//   take rx_data before the next rx_done.
//  Receiver tolerates up to +/-4% baud mismatch (centre sampling, no resync within frame).
//  No blocking timing controls, no mixed blocking/nonblocking on one variable; single
//   always_ff for state, one combinational next-state block permitted.
// TESTING (sim params clk_freq=1_000_000, baud_rate=100_000 -> baud_tick=10, half_tick=5)
//  T1 reset: hold rst=0, rx=1 -> all outputs 0, busy 0; release, idle 20 clk -> no pulses.
//  T2 frame 0xA5 (rx: 0,1,0,1,0,0,1,0,1,1 @10 clk/bit) -> rx_done 1 clk, rx_data=8'hA5,
//   frame_err never high, busy falls with rx_done.
//  T3 back-to-back 0x00 then 0xFF, no idle gap -> two rx_done pulses, data 00 then FF.
//  T4 stop bit 0 on byte 0x3C, then line held low 30 clk, then high -> one frame_err pulse,
//   rx_data keeps prior value, no new frame started until line high.
//  T5 3-clk low glitch on idle line -> no rx_done/frame_err, returns IDLE, next 0x5A ok.
//  T6 rst=0 asserted in DATA after 4 bits, released, then send 0x81 -> only 0x81 reported;
//   also loopback with uart_tx (same params) sending 0x00,0x55,0xFF -> bytes match in order.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte bundle for uart_rx
interface uart_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   modport master (
      input  rx,
      output rx_data,
      output rx_done,
      output frame_err,
      output busy
   );

   modport slave (
      output rx,
      input  rx_data,
      input  rx_done,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling and framing check
module uart_rx #(
   parameter int clk_freq  = 50_000_000,
   parameter int baud_rate = 9600
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.master bus
);

   localparam int          baud_tick = clk_freq / baud_rate;
   localparam int          half_tick = baud_tick / 2;
   localparam logic [12:0] tick_last = 13'(baud_tick - 1);
   localparam logic [12:0] half_last = 13'(half_tick - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state;
   logic        sync1;
   logic        rx_s;
   logic        armed;
   logic [12:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [7:0]  shift;
   logic [7:0]  data_q;
   logic        done_q;
   logic        err_q;
   logic        busy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sync1    <= 1'b1;
         rx_s     <= 1'b1;
         armed    <= 1'b0;
         baud_cnt <= 13'd0;
         bit_cnt  <= 4'd0;
         shift    <= 8'h00;
         data_q   <= 8'h00;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sync1  <= bus.rx;
         rx_s   <= sync1;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               // a line held low since reset or a break must go high before a start counts
               if (rx_s) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  state    <= START;
                  baud_cnt <= 13'd0;
                  busy_q   <= 1'b1;
               end
            end
            START: begin
               if (baud_cnt == half_last) begin
                  baud_cnt <= 13'd0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_cnt <= 4'd0;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 13'd1;
               end
            end
            DATA: begin
               if (baud_cnt == tick_last) begin
                  baud_cnt <= 13'd0;
                  shift    <= {rx_s, shift[7:1]};
                  bit_cnt  <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     state <= STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 13'd1;
               end
            end
            STOP: begin
               if (baud_cnt == tick_last) begin
                  baud_cnt <= 13'd0;
                  state    <= IDLE;
                  busy_q   <= 1'b0;
                  if (rx_s) begin
                     data_q <= shift;
                     done_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                     armed <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 13'd1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_done   = done_q;
   assign bus.frame_err = err_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with a frame-level scoreboard
module tb_uart_rx;

   localparam int bit_clks = 10;

   typedef struct {
      logic       err;
      logic [7:0] data;
      int         t0;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   tests;
   int   fails;
   int   done_cnt;
   int   err_cnt;
   ev_t  q[$];

   uart_rx_if u_if ();

   uart_rx #(
      .clk_freq  (1_000_000),
      .baud_rate (100_000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic drive_bit(input logic b);
      u_if.rx = b;
      repeat (bit_clks) @(negedge clk);
   endtask

   // Behaves like the matching transmitter: start, 8 bits LSB first, stop.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      ev_t e;
      e.err  = !stop;
      e.data = d;
      e.t0   = cyc;
      q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   task automatic idle(input int n);
      u_if.rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] model_data;
      logic       prev_pulse;
      logic       prev_busy;
      logic [7:0] part;
      tests    = 0;
      fails    = 0;
      done_cnt = 0;
      err_cnt  = 0;
      rst      = 1'b0;
      u_if.rx  = 1'b1;

      fork
         begin
            model_data = 8'h00;
            prev_pulse = 1'b0;
            prev_busy  = 1'b0;
            forever begin
               @(negedge clk);
               if (!rst) begin
                  model_data = 8'h00;
                  prev_pulse = 1'b0;
                  prev_busy  = 1'b0;
                  continue;
               end
               if (u_if.rx_done || u_if.frame_err) begin
                  ev_t e;
                  check(!(u_if.rx_done && u_if.frame_err), "pulse_exclusive",
                        {u_if.rx_done, u_if.frame_err}, 0);
                  check(!prev_pulse, "pulse_width", 2, 1);
                  check(!u_if.busy && prev_busy, "busy_falls_with_pulse",
                        {prev_busy, u_if.busy}, 2);
                  if (q.size() == 0) begin
                     check(1'b0, "unexpected_pulse", {u_if.rx_done, u_if.frame_err}, 0);
                  end else begin
                     e = q.pop_front();
                     check(u_if.frame_err == e.err, "pulse_kind", u_if.frame_err, e.err);
                     check((cyc - e.t0) >= 97 && (cyc - e.t0) <= 99, "latency",
                           cyc - e.t0, 98);
                     if (!e.err) model_data = e.data;
                     check(u_if.rx_data == model_data, "rx_data_on_pulse",
                           u_if.rx_data, model_data);
                  end
                  if (u_if.rx_done) done_cnt++;
                  if (u_if.frame_err) err_cnt++;
               end else begin
                  check(u_if.rx_data == model_data, "rx_data_hold", u_if.rx_data, model_data);
               end
               prev_pulse = u_if.rx_done || u_if.frame_err;
               prev_busy  = u_if.busy;
            end
         end
      join_none

      // T1 reset
      repeat (5) @(negedge clk);
      check(u_if.rx_data == 8'h00, "reset_rx_data", u_if.rx_data, 8'h00);
      check({u_if.rx_done, u_if.frame_err, u_if.busy} == 3'b000, "reset_flags",
            {u_if.rx_done, u_if.frame_err, u_if.busy}, 0);
      rst = 1'b1;
      idle(20);
      check(done_cnt == 0 && err_cnt == 0 && !u_if.busy, "t1_quiet",
            done_cnt + err_cnt, 0);

      // T2 single frame
      send_frame(8'hA5, 1'b1);
      idle(10);
      check(u_if.rx_data == 8'hA5, "t2_data", u_if.rx_data, 8'hA5);
      check(done_cnt == 1 && err_cnt == 0, "t2_counts", done_cnt, 1);

      // T3 back-to-back frames
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(10);
      check(u_if.rx_data == 8'hFF, "t3_data", u_if.rx_data, 8'hFF);
      check(done_cnt == 3, "t3_counts", done_cnt, 3);

      // T4 bad stop bit then break
      send_frame(8'h3C, 1'b0);
      u_if.rx = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (u_if.busy) check(1'b0, "t4_no_start_while_low", 1, 0);
      end
      check(err_cnt == 1 && !u_if.busy, "t4_err_count", err_cnt, 1);
      idle(20);
      check(u_if.rx_data == 8'hFF, "t4_data_kept", u_if.rx_data, 8'hFF);
      check(done_cnt == 3 && err_cnt == 1, "t4_counts", done_cnt + err_cnt, 4);

      // T5 short glitch, then good frame
      u_if.rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(20);
      check(done_cnt == 3 && err_cnt == 1 && !u_if.busy, "t5_glitch_ignored",
            done_cnt + err_cnt, 4);
      send_frame(8'h5A, 1'b1);
      idle(10);
      check(u_if.rx_data == 8'h5A, "t5_data", u_if.rx_data, 8'h5A);

      // T6 reset in the middle of DATA, then recovery and a byte stream
      part = 8'h3C;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(part[i]);
      check(u_if.busy, "t6_busy_mid_frame", u_if.busy, 1);
      rst = 1'b0;
      u_if.rx = 1'b1;
      repeat (3) @(negedge clk);
      check(u_if.rx_data == 8'h00 && !u_if.busy, "t6_reset_mid_frame",
            u_if.rx_data, 8'h00);
      rst = 1'b1;
      idle(20);
      send_frame(8'h81, 1'b1);
      idle(10);
      check(u_if.rx_data == 8'h81, "t6_data", u_if.rx_data, 8'h81);
      send_frame(8'h00, 1'b1);
      send_frame(8'h55, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      check(u_if.rx_data == 8'hFF, "t6_loop_last", u_if.rx_data, 8'hFF);
      check(done_cnt == 8 && err_cnt == 1, "t6_counts", done_cnt, 8);
      check(q.size() == 0, "all_events_seen", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
